// File: rtl/random_walk_pkg.sv
// Shared types and helpers for the random-walk sprite mover.
// Optional feature macro: RANDOM_WALK_DIAGONAL_EN widens the heading to 3 bits
// and adds four diagonal headings (UR, UL, DR, DL).
package random_walk_pkg;

`ifdef RANDOM_WALK_DIAGONAL_EN
    localparam int unsigned HEAD_W = 3;
`else
    localparam int unsigned HEAD_W = 2;
`endif

    typedef enum logic [HEAD_W-1:0] {
        H_UP    = HEAD_W'(0),
        H_DOWN  = HEAD_W'(1),
        H_RIGHT = HEAD_W'(2),
        H_LEFT  = HEAD_W'(3)
`ifdef RANDOM_WALK_DIAGONAL_EN
        ,
        H_UR    = HEAD_W'(4),
        H_UL    = HEAD_W'(5),
        H_DR    = HEAD_W'(6),
        H_DL    = HEAD_W'(7)
`endif
    } heading_t;

    // Walker FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WALK   = 2'd1;
    localparam state_t ST_FROZEN = 2'd2;

    // Per-axis step direction: -1, 0 or +1
    typedef logic signed [1:0] dir_t;

    // Horizontal component of a heading
    function automatic dir_t dir_x(input heading_t h);
        case (h)
            H_RIGHT: dir_x = 2'sb01;
            H_LEFT:  dir_x = 2'sb11;
`ifdef RANDOM_WALK_DIAGONAL_EN
            H_UR, H_DR: dir_x = 2'sb01;
            H_UL, H_DL: dir_x = 2'sb11;
`endif
            default: dir_x = 2'sb00;
        endcase
    endfunction

    // Vertical component of a heading (screen Y grows downward)
    function automatic dir_t dir_y(input heading_t h);
        case (h)
            H_UP:   dir_y = 2'sb11;
            H_DOWN: dir_y = 2'sb01;
`ifdef RANDOM_WALK_DIAGONAL_EN
            H_UR, H_UL: dir_y = 2'sb11;
            H_DR, H_DL: dir_y = 2'sb01;
`endif
            default: dir_y = 2'sb00;
        endcase
    endfunction

    // Mirror each heading component whose axis hit a wall
    function automatic heading_t reflect(input heading_t h, input logic hit_x, input logic hit_y);
        reflect = h;
        case (h)
            H_UP:    if (hit_y) reflect = H_DOWN;
            H_DOWN:  if (hit_y) reflect = H_UP;
            H_RIGHT: if (hit_x) reflect = H_LEFT;
            H_LEFT:  if (hit_x) reflect = H_RIGHT;
`ifdef RANDOM_WALK_DIAGONAL_EN
            H_UR: if (hit_x && hit_y) reflect = H_DL; else if (hit_x) reflect = H_UL; else if (hit_y) reflect = H_DR;
            H_UL: if (hit_x && hit_y) reflect = H_DR; else if (hit_x) reflect = H_UR; else if (hit_y) reflect = H_DL;
            H_DR: if (hit_x && hit_y) reflect = H_UL; else if (hit_x) reflect = H_DL; else if (hit_y) reflect = H_UR;
            H_DL: if (hit_x && hit_y) reflect = H_UR; else if (hit_x) reflect = H_DR; else if (hit_y) reflect = H_UL;
`endif
            default: reflect = h;
        endcase
    endfunction

endpackage

// File: rtl/axis_step_clamp.sv
// One-axis step with wall clamp.
// Ports: pos (current coordinate), dir (-1/0/+1), min_pos/max_pos (inclusive
// bounds), next_pos (stepped and clamped coordinate), hit (clamp occurred).
module axis_step_clamp
    import random_walk_pkg::*;
#(
    parameter int unsigned COORD_W = 11,
    parameter int unsigned SPEED   = 3
) (
    input  logic [COORD_W-1:0] pos,
    input  dir_t               dir,
    input  logic [COORD_W-1:0] min_pos,
    input  logic [COORD_W-1:0] max_pos,
    output logic [COORD_W-1:0] next_pos,
    output logic               hit
);
    localparam int unsigned EXT_W = COORD_W + 1;

    logic signed [EXT_W-1:0] pos_s, min_s, max_s, step_s, next_s;

    // Signed one-bit-wider arithmetic so a step below zero is still detectable
    always_comb begin
        pos_s  = signed'({1'b0, pos});
        min_s  = signed'({1'b0, min_pos});
        max_s  = signed'({1'b0, max_pos});
        step_s = EXT_W'(SPEED);
        case (dir)
            2'sb01:  next_s = pos_s + step_s;
            2'sb11:  next_s = pos_s - step_s;
            default: next_s = pos_s;
        endcase
        next_pos = COORD_W'(next_s);
        hit      = 1'b0;
        if (next_s < min_s) begin
            next_pos = min_pos;
            hit      = 1'b1;
        end else if (next_s > max_s) begin
            next_pos = max_pos;
            hit      = 1'b1;
        end
    end

endmodule

// File: rtl/random_walk_mover.sv
// Random-walk mover for NPC sprites: steps the object's top-left corner once
// per timer_done tick, holding a random heading for HOLD_STEPS ticks, clamping
// and reflecting at the arena walls, with freeze and respawn.
// Optional feature macro: RANDOM_WALK_DIAGONAL_EN (3-bit heading with diagonals).
// Ports: CLK, RESET (sync, active-high), timer_done (step strobe), enable,
// freeze, respawn, random[3:0] (LFSR sample); ObjectStartX/ObjectStartY
// (position), heading, moving (position changed on last tick), wall_hit
// (last tick clamped).
module random_walk_mover
    import random_walk_pkg::*;
#(
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned X_INIT      = 200,
    parameter int unsigned Y_INIT      = 250,
    parameter int unsigned SPEED       = 3,
    parameter int unsigned HOLD_STEPS  = 5,
    parameter int unsigned OBJ_W       = 26,
    parameter int unsigned OBJ_H       = 26,
    parameter int unsigned LIMIT_LEFT  = 45,
    parameter int unsigned LIMIT_RIGHT = 635,
    parameter int unsigned LIMIT_UP    = 85,
    parameter int unsigned LIMIT_DOWN  = 400
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               timer_done,
    input  logic               enable,
    input  logic               freeze,
    input  logic               respawn,
    input  logic [3:0]         random,
    output logic [COORD_W-1:0] ObjectStartX,
    output logic [COORD_W-1:0] ObjectStartY,
    output logic [HEAD_W-1:0]  heading,
    output logic               moving,
    output logic               wall_hit
);
    localparam int unsigned XMAX   = LIMIT_RIGHT - OBJ_W;
    localparam int unsigned YMAX   = LIMIT_DOWN - OBJ_H;
    localparam int unsigned HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [COORD_W-1:0] X_LO = COORD_W'(LIMIT_LEFT);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(XMAX);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(LIMIT_UP);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(YMAX);

    // Arena must leave room for at least one full step on each axis
    if (!(XMAX > LIMIT_LEFT + SPEED) || !(YMAX > LIMIT_UP + SPEED) || (HOLD_STEPS < 1)) begin : g_bad_params
        $error("random_walk_mover: arena too small for SPEED or HOLD_STEPS < 1");
    end

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    heading_t             head_q, head_d, tick_head;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 moving_q, moving_d, hit_q, hit_d;
    logic [COORD_W-1:0]   x_next, y_next;
    logic                 hit_x, hit_y;
    dir_t                 step_dx, step_dy;

    logic unused_random_hi;
    assign unused_random_hi = ^random[3:HEAD_W];

    // Heading used by a tick: a fresh pick when the hold has run out
    always_comb begin
        tick_head = head_q;
        if (hold_q == '0) tick_head = heading_t'(random[HEAD_W-1:0]);
        step_dx = dir_x(tick_head);
        step_dy = dir_y(tick_head);
    end

    axis_step_clamp #(.COORD_W(COORD_W), .SPEED(SPEED)) u_axis_x (
        .pos(x_q), .dir(step_dx), .min_pos(X_LO), .max_pos(X_HI), .next_pos(x_next), .hit(hit_x)
    );

    axis_step_clamp #(.COORD_W(COORD_W), .SPEED(SPEED)) u_axis_y (
        .pos(y_q), .dir(step_dy), .min_pos(Y_LO), .max_pos(Y_HI), .next_pos(y_next), .hit(hit_y)
    );

    // State register and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            x_q      <= COORD_W'(X_INIT);
            y_q      <= COORD_W'(Y_INIT);
            head_q   <= H_RIGHT;
            hold_q   <= '0;
            moving_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            head_q   <= head_d;
            hold_q   <= hold_d;
            moving_q <= moving_d;
            hit_q    <= hit_d;
        end
    end

    // Next-state and datapath update; respawn > freeze > tick
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        head_d   = head_q;
        hold_d   = hold_q;
        moving_d = 1'b0;
        hit_d    = 1'b0;
        if (respawn) begin
            x_d     = COORD_W'(X_INIT);
            y_d     = COORD_W'(Y_INIT);
            head_d  = H_RIGHT;
            hold_d  = '0;
            state_d = enable ? ST_WALK : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_WALK;
                end
                ST_WALK: begin
                    if (freeze) begin
                        state_d = ST_FROZEN;
                    end else if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (timer_done) begin
                        hold_d   = (hold_q == '0) ? HOLD_W'(HOLD_STEPS - 1) : hold_q - HOLD_W'(1);
                        x_d      = x_next;
                        y_d      = y_next;
                        head_d   = reflect(tick_head, hit_x, hit_y);
                        moving_d = (x_next != x_q) || (y_next != y_q);
                        hit_d    = hit_x | hit_y;
                    end
                end
                ST_FROZEN: begin
                    if (!freeze) state_d = ST_WALK;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ObjectStartX = x_q;
    assign ObjectStartY = y_q;
    assign heading      = head_q;
    assign moving       = moving_q;
    assign wall_hit     = hit_q;

endmodule

// File: tb/tb_random_walk_mover.sv
// Bench for random_walk_mover: two instances (default spawn, and a spawn near
// the top/right walls) share stimulus and are compared every cycle against a
// behavioural model, plus directed scenario checks.
module tb_random_walk_mover;
    import random_walk_pkg::*;

    localparam int CW    = 11;
    localparam int SPEED = 3;
    localparam int HOLD  = 5;
    localparam int LEFT  = 45;
    localparam int XMAX  = 635 - 26;
    localparam int UP    = 85;
    localparam int YMAX  = 400 - 26;
`ifdef RANDOM_WALK_DIAGONAL_EN
    localparam int NHEAD = 8;
`else
    localparam int NHEAD = 4;
`endif

    logic CLK = 1'b0;
    logic RESET = 1'b0, timer_done = 1'b0, enable = 1'b0, freeze = 1'b0, respawn = 1'b0;
    logic [3:0] random = 4'd0;
    logic [CW-1:0] x0, y0, x1, y1;
    logic [HEAD_W-1:0] h0, h1;
    logic mv0, mv1, wh0, wh1;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per-instance spawn point and state (mode 0 idle, 1 walk, 2 frozen)
    int p_xi[2] = '{200, 607};
    int p_yi[2] = '{250, 87};
    int m_x[2], m_y[2], m_h[2], m_hold[2], m_mode[2], m_mv[2], m_hit[2];
    int dx_tab[8] = '{0, 0, 1, -1, 1, -1, 1, -1};
    int dy_tab[8] = '{-1, 1, 0, 0, -1, -1, 1, 1};

    always #5 CLK = ~CLK;

    random_walk_mover u0 (
        .CLK(CLK), .RESET(RESET), .timer_done(timer_done), .enable(enable), .freeze(freeze),
        .respawn(respawn), .random(random), .ObjectStartX(x0), .ObjectStartY(y0),
        .heading(h0), .moving(mv0), .wall_hit(wh0)
    );

    random_walk_mover #(.X_INIT(607), .Y_INIT(87)) u1 (
        .CLK(CLK), .RESET(RESET), .timer_done(timer_done), .enable(enable), .freeze(freeze),
        .respawn(respawn), .random(random), .ObjectStartX(x1), .ObjectStartY(y1),
        .heading(h1), .moving(mv1), .wall_hit(wh1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge of the walker rules to model instance i
    task automatic model_edge(input int i);
        int nx, ny, dx, dy;
        bit hx, hy;
        if (RESET) begin
            m_x[i] = p_xi[i]; m_y[i] = p_yi[i]; m_h[i] = 2; m_hold[i] = 0;
            m_mode[i] = 0; m_mv[i] = 0; m_hit[i] = 0;
            return;
        end
        m_mv[i] = 0; m_hit[i] = 0;
        if (respawn) begin
            m_x[i] = p_xi[i]; m_y[i] = p_yi[i]; m_h[i] = 2; m_hold[i] = 0;
            m_mode[i] = enable ? 1 : 0;
        end else if (m_mode[i] == 0) begin
            if (enable) m_mode[i] = 1;
        end else if (m_mode[i] == 2) begin
            if (!freeze) m_mode[i] = 1;
        end else if (freeze) begin
            m_mode[i] = 2;
        end else if (!enable) begin
            m_mode[i] = 0;
        end else if (timer_done) begin
            if (m_hold[i] == 0) begin
                m_h[i] = int'(random) % NHEAD;
                m_hold[i] = HOLD - 1;
            end else begin
                m_hold[i]--;
            end
            dx = dx_tab[m_h[i]];
            dy = dy_tab[m_h[i]];
            nx = m_x[i] + dx * SPEED;
            ny = m_y[i] + dy * SPEED;
            hx = 0; hy = 0;
            if (nx < LEFT) begin nx = LEFT; hx = 1; end
            else if (nx > XMAX) begin nx = XMAX; hx = 1; end
            if (ny < UP) begin ny = UP; hy = 1; end
            else if (ny > YMAX) begin ny = YMAX; hy = 1; end
            m_mv[i]  = (nx != m_x[i] || ny != m_y[i]) ? 1 : 0;
            m_hit[i] = (hx || hy) ? 1 : 0;
            if (hx) dx = -dx;
            if (hy) dy = -dy;
            for (int k = 0; k < NHEAD; k++)
                if (dx_tab[k] == dx && dy_tab[k] == dy) m_h[i] = k;
            m_x[i] = nx;
            m_y[i] = ny;
        end
    endtask

    task automatic cmp_inst(input int i, input int ax, input int ay, input int ah, input int amv, input int ahit);
        check_eq($sformatf("u%0d.x", i), ax, m_x[i]);
        check_eq($sformatf("u%0d.y", i), ay, m_y[i]);
        check_eq($sformatf("u%0d.heading", i), ah, m_h[i]);
        check_eq($sformatf("u%0d.moving", i), amv, m_mv[i]);
        check_eq($sformatf("u%0d.wall_hit", i), ahit, m_hit[i]);
    endtask

    // Drive inputs, take one edge, advance the model, then compare #1 later
    task automatic step(input logic rst, input logic tick, input logic en, input logic frz,
                        input logic rsp, input logic [3:0] rnd);
        RESET = rst; timer_done = tick; enable = en; freeze = frz; respawn = rsp; random = rnd;
        @(posedge CLK);
        model_edge(0);
        model_edge(1);
        #1;
        cmp_inst(0, int'(x0), int'(y0), int'(h0), int'(mv0), int'(wh0));
        cmp_inst(1, int'(x1), int'(y1), int'(h1), int'(mv1), int'(wh1));
    endtask

    initial begin
        logic frz_hold;
        // Reset and idle ticks
        step(1, 0, 0, 0, 0, 4'd0);
        step(1, 0, 0, 0, 0, 4'd0);
        check_eq("rst.x", int'(x0), 200);
        check_eq("rst.y", int'(y0), 250);
        check_eq("rst.heading", int'(h0), 2);
        check_eq("rst.moving", int'(mv0), 0);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0, 4'b0010);
        check_eq("idle.x", int'(x0), 200);
        check_eq("idle.y", int'(y0), 250);

        // Enable, first pick RIGHT held for 5 ticks, repick UP on tick 6
        step(0, 0, 1, 0, 0, 4'd0);
        check_eq("enable.no_move", int'(x0), 200);
        step(0, 1, 1, 0, 0, 4'b0010);
        check_eq("walk.x1", int'(x0), 203);
        for (int k = 1; k < 5; k++) begin
            step(0, 1, 1, 0, 0, 4'b0000);
            check_eq($sformatf("walk.x%0d", k + 1), int'(x0), 203 + 3 * k);
        end
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("repick.y", int'(y0), 247);
        check_eq("repick.x", int'(x0), 215);
        check_eq("repick.heading", int'(h0), 0);

        // Top wall clamp and reflect on u1 (Y spawn 87)
        step(0, 0, 1, 0, 1, 4'd0);
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("top.y", int'(y1), 85);
        check_eq("top.wall_hit", int'(wh1), 1);
        check_eq("top.heading", int'(h1), 1);
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("top.y_after", int'(y1), 88);
        check_eq("top.moving_after", int'(mv1), 1);
        check_eq("top.hit_after", int'(wh1), 0);

        // Right wall clamp and reflect on u1 (X spawn 607)
        step(0, 0, 1, 0, 1, 4'd0);
        step(0, 1, 1, 0, 0, 4'b0010);
        check_eq("right.x", int'(x1), 609);
        check_eq("right.wall_hit", int'(wh1), 1);
        check_eq("right.heading", int'(h1), 3);
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("right.x_after", int'(x1), 606);

        // Freeze after two ticks of a hold, then resume the remaining three
        step(0, 0, 1, 0, 1, 4'd0);
        step(0, 1, 1, 0, 0, 4'b0010);
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("frz.x_before", int'(x0), 206);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 1, 0, 4'($urandom_range(0, 15)));
        check_eq("frz.x_held", int'(x0), 206);
        check_eq("frz.moving", int'(mv0), 0);
        step(0, 0, 1, 0, 0, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 1, 1, 0, 0, 4'b0000);
            check_eq($sformatf("resume.x%0d", k), int'(x0), 206 + 3 * k);
        end
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("resume.repick_y", int'(y0), 247);

        // Respawn wins over a coincident tick; hold restarts from zero
        step(0, 1, 1, 0, 0, 4'd0);
        step(0, 1, 1, 0, 1, 4'b0001);
        check_eq("rsp.x", int'(x0), 200);
        check_eq("rsp.y", int'(y0), 250);
        check_eq("rsp.heading", int'(h0), 2);
        check_eq("rsp.moving", int'(mv0), 0);
        step(0, 1, 1, 0, 0, 4'b0000);
        check_eq("rsp.fresh_pick_y", int'(y0), 247);

        // RESET pulse that never meets a clock edge has no effect
        RESET = 1'b1;
        #2;
        check_eq("glitch.x", int'(x0), 200);
        check_eq("glitch.y", int'(y0), 247);
        RESET = 1'b0;
        step(0, 1, 1, 0, 0, 4'b0010);
        check_eq("glitch.y_next", int'(y0), 244);

        // Randomized traffic against the model
        frz_hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) frz_hold = ~frz_hold;
            step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) != 0), frz_hold,
                 1'($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/random_walk_mover.md
Name: random_walk_mover

Overview:
Parametrised successor of the single-sprite random mover for NPC sprites such as the french character. It walks an object's top-left corner inside a rectangular arena, one step per `timer_done` tick. A random heading is held for `HOLD_STEPS` ticks. On a wall it clamps to the wall and reflects instead of stalling, and it supports freeze and respawn. It sits between the game timer/LFSR and the sprite draw/collision logic.

Parameters:
COORD_W, 11, coordinate width.
X_INIT, 200, respawn/reset X.
Y_INIT, 250, respawn/reset Y.
SPEED, 3, pixels per step on each moving axis.
HOLD_STEPS, 5, ticks per heading (>=1).
OBJ_W, 26, object width.
OBJ_H, 26, object height.
LIMIT_LEFT, 45, minimum X.
LIMIT_RIGHT, 635, maximum X+OBJ_W.
LIMIT_UP, 85, minimum Y.
LIMIT_DOWN, 400, maximum Y+OBJ_H.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous active-high reset
timer_done  in  1  step strobe, one CLK wide
enable  in  1  leave IDLE / allow walking
freeze  in  1  hold position and counters while high
respawn  in  1  synchronous reload to X_INIT/Y_INIT
random  in  4  LFSR sample
ObjectStartX  out  COORD_W  object top-left X
ObjectStartY  out  COORD_W  object top-left Y
heading  out  2  current heading: 00 UP, 01 DOWN, 10 RIGHT, 11 LEFT
moving  out  1  high for the cycle after a tick that changed position
wall_hit  out  1  one-cycle pulse after a tick that clamped

Behaviour:
- Interface: one clock `CLK`; reset `RESET` is synchronous, active-high; it is sampled only at the CLK edge.
- Reset values: ObjectStartX=X_INIT, ObjectStartY=Y_INIT, heading=RIGHT, moving=0, wall_hit=0, hold_cnt=0, state=IDLE.
- Priority each edge: RESET > respawn > freeze > timer_done.
- Derived bounds: XMAX=LIMIT_RIGHT-OBJ_W and YMAX=LIMIT_DOWN-OBJ_H. Elaboration fails unless XMAX>LIMIT_LEFT+SPEED and YMAX>LIMIT_UP+SPEED.
- States:
  - IDLE: outputs held. Goes to WALK on enable=1; no move on that edge.
  - WALK: processes ticks. Goes to FROZEN if freeze=1. Goes to IDLE if enable=0.
  - FROZEN: position, heading and hold_cnt held. Returns to WALK when freeze=0; the first tick after release uses the remaining hold_cnt.
- Tick in WALK:
  - If hold_cnt==0: heading<=random[1:0] and hold_cnt<=HOLD_STEPS-1. The move uses the new heading on the same tick.
  - Else: hold_cnt decrements and random is ignored.
- Move arithmetic: next coordinate computed at COORD_W+1 bits signed, pos±SPEED.
  - If next<lower bound or >upper bound: the coordinate is clamped to that bound, heading reflects (UP<->DOWN, LEFT<->RIGHT) and wall_hit pulses. hold_cnt is not reset.
  - Object already at the bound moving outward: position unchanged, moving=0, reflect.
- moving=1 iff the coordinate changed on that tick. moving and wall_hit are registered, valid for the one cycle after the tick, and 0 otherwise.
- respawn: X/Y<=init, hold_cnt<=0, heading<=RIGHT. State goes to WALK if enable=1, else IDLE. A coincident tick is ignored.
- RESET mid-walk discards hold_cnt and heading.

Optional Feature:
RANDOM_WALK_DIAGONAL_EN
- Defined: heading widens to 3 bits and takes random[2:0]. Values 100–111 are diagonals UR, UL, DR, DL, each moving SPEED on both axes.
  - Each axis clamps and reflects independently; hitting a corner reflects both components.
  - random[3] still ignored.
- Undefined: heading is 2 bits, random[3:2] ignored, behaviour as above.

Decomposition:
- Package `random_walk_pkg`: heading enum (UP, DOWN, RIGHT, LEFT, and diagonals under the macro), state enum (IDLE, WALK, FROZEN), and a `reflect()` function.
- One sub-module `axis_step_clamp`, instanced for X and Y. Inputs: pos, dir (-1/0/+1), min, max, SPEED. Outputs: next_pos, hit.

Test Plan:
1. RESET=1 for 2 cycles → X=200, Y=250, heading=10, moving=0. With enable=0, 10 ticks → outputs unchanged.
2. enable=1, random=4'b0010, 6 ticks (random changed to 0000 after the first) → X=203,206,209,212,215, then a new pick UP on tick 6 → Y=247.
3. Bench Y_INIT=87, random=0000, one tick → Y=85 clamped, wall_hit pulse, heading=01. Next tick → Y=88, moving=1, wall_hit=0.
4. Bench X_INIT=607, random=0010 → X=609 with wall_hit, heading=11. Next tick → X=606.
5. freeze=1 after tick 2 of a hold, 8 ticks → X/Y/hold_cnt frozen. Release → 3 more steps in the old heading, then a repick.
6. respawn and timer_done asserted on the same edge mid-walk → X=200, Y=250, hold_cnt=0, no step. RESET pulsed between edges → no effect until the next CLK edge.
